udm_uart_rx: RTL and testbench
==============================

# udm_uart_rx

UART receiver that deserialises the asynchronous serial input into bytes for the UDM debug controller. It sits directly upstream of the controller's rx interface and drives `rx_done_tick_o` and `rx_dout_bo`, which connect to the controller's `rx_done_tick_i` and `rx_din_bi`. It uses 16x oversampling with 3-sample majority voting, rejects false starts, and flags framing errors.

## Interface
Parameters:
- `DIV_WIDTH`, 16: width of the baud divider input.

Ports:
- `clk_i`  in  1  system clock.
- `reset_n_i`  in  1  reset. One clock; reset is asynchronous and active-low.
- `rx_i`  in  1  serial line. Asynchronous to `clk_i`; idle level is 1.
- `baud_div_bi`  in  DIV_WIDTH  clk cycles per oversample tick, minus 1. Bit period = 16*(baud_div_bi+1) clk.
- `rx_done_tick_o`  out  1  one-cycle pulse when a valid byte is received.
- `rx_dout_bo`  out  8  received byte. Valid with `rx_done_tick_o` and held until the next valid byte.
- `frame_err_o`  out  1  one-cycle pulse when the stop bit is sampled as 0.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- Input synchroniser: 2 flops on `rx_i`, both reset to 1. All logic below uses the synchronised value `rxs`.
- Tick generator:
  - `div_cnt` is held at 0 in IDLE and BREAK.
  - Otherwise it counts 0..`div_ff` and wraps. `os_tick` is asserted when `div_cnt==div_ff`.
  - `div_ff` latches `baud_div_bi` on the IDLE->START transition, so divider changes mid-frame are ignored.
- `os_cnt` (4 bit) increments on each `os_tick` and wraps 15->0. Each wrap ends one bit period.
- Majority: `rxs` is sampled on the `os_tick` where `os_cnt` is 7, 8 and 9. Bit value = majority of the three samples, valid once `os_cnt` reaches 10.
- FSM states:
  - IDLE: when `rxs==0`, clear `os_cnt` and `div_cnt`, latch `div_ff`, go to START.
  - START: at the end of the bit period (`os_tick` with `os_cnt==15`):
    - majority 1 (false start, glitch): return to IDLE, no output pulse.
    - majority 0: go to DATA with `bit_cnt=0`.
  - DATA: at the end of each bit period, `shreg <= {maj, shreg[7:1]}` (LSB first) and `bit_cnt++`. After bit 7 completes, go to STOP.
  - STOP: evaluated early, at the `os_tick` with `os_cnt==9`, to allow resync to the next start bit:
    - majority 1: `rx_dout_bo <= shreg`, pulse `rx_done_tick_o`, go to IDLE.
    - majority 0: pulse `frame_err_o`, leave `rx_dout_bo` unchanged, go to BREAK.
  - BREAK: wait for `rxs==1`, then go to IDLE. This prevents a held-low line from being taken as a new start.
- The receiver never interprets byte values; SYNC and ESCAPE handling belongs to the downstream controller.

## Timing
- Reset values: `rx_done_tick_o`=0, `frame_err_o`=0, `busy_o`=0, `rx_dout_bo`=8'h00, state=IDLE, `shreg`=0, all counters 0.
- `reset_n_i` asserted mid-frame aborts immediately. No pulse is produced; after release the block waits in IDLE for the next falling edge.
- Start detect: START is entered 3 clk after the falling edge on `rx_i` (2 synchroniser flops plus 1 FSM registration).
- Output latency: `rx_done_tick_o` rises in the cycle after the stop-bit decision tick, i.e. 9.625 bit periods after the start edge (+3 clk).
- `rx_done_tick_o` and `frame_err_o` are mutually exclusive and never longer than 1 cycle.
- Back-to-back frames: a start edge arriving from stop-bit sample 10 onward is accepted. The IDLE dwell is 1 cycle.
- `baud_div_bi==0`: `os_tick` every cycle, bit period = 16 clk. This is legal.

## Structure
- Shared package `udm_pkg`: FSM state encoding (IDLE, START, DATA, STOP, BREAK), `OVERSAMPLE=16`, sample indices 7/8/9, and `SYNC_BYTE`/`ESCAPE_BYTE` for the bench.
- One natural sub-module: `udm_baud_tick`, which holds `div_ff`, `div_cnt` and `os_tick`, with a synchronous clear input driven by the FSM.

## Test plan
- `baud_div_bi`=0, send 0xA5 with a valid stop bit -> one `rx_done_tick_o`, `rx_dout_bo`=0xA5, `frame_err_o` stays 0.
- `rx_i` low for 5 clk then high (glitch), `baud_div_bi`=0 -> START then IDLE, no pulse on either output, `rx_dout_bo` unchanged.
- Send 0x3C with the stop bit forced to 0, line held low for 40 clk -> `frame_err_o` pulses once, `rx_dout_bo` keeps its previous value, state stays BREAK until the line goes high, then the next byte 0x55 is received correctly.
- `baud_div_bi`=3, send 0x55 then 0x5A with zero gap between frames -> two done ticks carrying 0x55 and 0x5A.
- Single-clk low spike at sample 8 of data bit 2 while sending 0xFF -> majority vote corrects it, output 0xFF.
- Assert `reset_n_i` low during DATA bit 4 of a frame, release, then send 0x81 -> only 0x81 is reported, and `rx_dout_bo` reads 0x00 until that byte arrives.

Source files
------------

// File: rtl/udm_pkg.sv
// Shared definitions for the UDM debug controller serial front end.
package udm_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  // Oversampling factor and the majority-vote sample positions within a bit
  localparam int unsigned OVERSAMPLE = 16;
  localparam logic [3:0]  OS_LAST    = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]  SAMPLE_A   = 4'd7;
  localparam logic [3:0]  SAMPLE_B   = 4'd8;
  localparam logic [3:0]  SAMPLE_C   = 4'd9;

  // Protocol bytes interpreted by the downstream controller, not by the receiver
  localparam logic [7:0]  SYNC_BYTE   = 8'h55;
  localparam logic [7:0]  ESCAPE_BYTE = 8'h5A;

  // 2-of-3 majority vote
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/udm_baud_tick.sv
// Oversample tick generator: one tick every (div_ff+1) clocks while running.
module udm_baud_tick #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 clr_i,
  input  logic                 load_i,
  input  logic [DIV_WIDTH-1:0] baud_div_bi,
  output logic                 os_tick_o
);

  logic [DIV_WIDTH-1:0] div_ff;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 cnt_hit;

  assign cnt_hit   = (div_cnt == div_ff);
  // No ticks while held in clear, so the oversample counter stays put
  assign os_tick_o = cnt_hit && !clr_i;

  // Divider snapshot, taken only at the start of a frame
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      div_ff <= '0;
    end else if (load_i) begin
      div_ff <= baud_div_bi;
    end
  end

  // Wrapping divider counter with synchronous clear
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      div_cnt <= '0;
    end else if (clr_i || cnt_hit) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/udm_uart_rx.sv
// UART receiver: 16x oversampling, 3-sample majority vote, false-start
// rejection and framing-error detection. Feeds the UDM controller rx port.
module udm_uart_rx
  import udm_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 rx_i,
  input  logic [DIV_WIDTH-1:0] baud_div_bi,
  output logic                 rx_done_tick_o,
  output logic [7:0]           rx_dout_bo,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  logic      rx_meta;
  logic      rxs;
  rx_state_t state;
  logic [3:0] os_cnt;
  logic [2:0] bit_cnt;
  logic [2:0] smp;
  logic [7:0] shreg;
  logic       os_tick;
  logic       tick_clr;
  logic       tick_load;
  logic       bit_maj;
  logic       stop_maj;

  // Two-flop synchroniser, idle-high
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
    end
  end

  assign tick_clr  = (state == ST_IDLE) || (state == ST_BREAK);
  assign tick_load = (state == ST_IDLE) && !rxs;

  udm_baud_tick #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_tick (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .clr_i       (tick_clr),
    .load_i      (tick_load),
    .baud_div_bi (baud_div_bi),
    .os_tick_o   (os_tick)
  );

  // Full-bit decisions use the three stored samples; the stop bit is decided
  // on the third sample tick itself, so the live input stands in for sample C.
  assign bit_maj  = maj3(smp[0], smp[1], smp[2]);
  assign stop_maj = maj3(smp[0], smp[1], rxs);
  assign busy_o   = (state != ST_IDLE);

  // Receive FSM with oversample counting, sampling and registered outputs
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state          <= ST_IDLE;
      os_cnt         <= '0;
      bit_cnt        <= '0;
      smp            <= '0;
      shreg          <= '0;
      rx_dout_bo     <= '0;
      rx_done_tick_o <= 1'b0;
      frame_err_o    <= 1'b0;
    end else begin
      rx_done_tick_o <= 1'b0;
      frame_err_o    <= 1'b0;

      if (os_tick) begin
        os_cnt <= os_cnt + 4'd1;
        if (os_cnt == SAMPLE_A) smp[0] <= rxs;
        if (os_cnt == SAMPLE_B) smp[1] <= rxs;
        if (os_cnt == SAMPLE_C) smp[2] <= rxs;
      end

      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            os_cnt <= '0;
            state  <= ST_START;
          end
        end
        ST_START: begin
          if (os_tick && os_cnt == OS_LAST) begin
            if (bit_maj) begin
              state <= ST_IDLE;
            end else begin
              bit_cnt <= '0;
              state   <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (os_tick && os_cnt == OS_LAST) begin
            shreg   <= {bit_maj, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (os_tick && os_cnt == SAMPLE_C) begin
            if (stop_maj) begin
              rx_dout_bo     <= shreg;
              rx_done_tick_o <= 1'b1;
              state          <= ST_IDLE;
            end else begin
              frame_err_o <= 1'b1;
              state       <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (rxs) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udm_uart_rx.sv
// Self-checking bench for udm_uart_rx: directed vectors, corner sequences and
// randomized frames checked against a frame-level expectation model.
module tb_udm_uart_rx;
  import udm_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        rx_i;
  logic [15:0] baud_div_bi;
  logic        rx_done_tick_o;
  logic [7:0]  rx_dout_bo;
  logic        frame_err_o;
  logic        busy_o;

  udm_uart_rx #(
    .DIV_WIDTH (16)
  ) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .rx_i           (rx_i),
    .baud_div_bi    (baud_div_bi),
    .rx_done_tick_o (rx_done_tick_o),
    .rx_dout_bo     (rx_dout_bo),
    .frame_err_o    (frame_err_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output event log, sampled on the falling edge
  typedef struct {
    int         at;
    logic [7:0] data;
  } evt_t;
  evt_t done_q[$];
  int   err_q[$];
  logic prev_done = 1'b0;
  logic prev_err  = 1'b0;

  always @(negedge clk_i) begin
    if (rx_done_tick_o || frame_err_o) begin
      chk("done_err_exclusive", 32'(rx_done_tick_o & frame_err_o), 32'd0);
      chk("pulse_single_cycle", 32'((rx_done_tick_o & prev_done) | (frame_err_o & prev_err)), 32'd0);
    end
    if (rx_done_tick_o) done_q.push_back('{cyc, rx_dout_bo});
    if (frame_err_o) err_q.push_back(cyc);
    prev_done = rx_done_tick_o;
    prev_err  = frame_err_o;
  end

  // Serial level for line bit index 0 (start) .. 8 (data MSB), 9 (stop)
  function automatic logic line_bit(input logic [7:0] b, input logic stop, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return stop;
    return b[idx-1];
  endfunction

  // Decision point: 9.625 bit periods after the start edge, plus 3 clocks
  function automatic int exp_decision(input int start, input int d);
    return start + 3 + (OVERSAMPLE * d * 77) / 8;
  endfunction

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic hold_low(input int n);
    rx_i = 1'b0;
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  // Drives one 10-bit frame at d clocks per oversample tick. Optional single-clock
  // low spike, optional reset abort, optional divider scramble mid-frame.
  task automatic drive_frame(input logic [7:0] b, input logic stop, input int d,
                             input int spike_off, input int abort_off,
                             input logic scramble, output int start_cyc);
    int bp;
    bp = OVERSAMPLE * d;
    baud_div_bi = 16'(d - 1);
    start_cyc = cyc;
    for (int i = 0; i < 10 * bp; i++) begin
      if (i == abort_off) begin
        reset_n_i = 1'b0;
        rx_i      = 1'b1;
        repeat (2) begin @(posedge clk_i); #1; end
        reset_n_i = 1'b1;
        return;
      end
      if (scramble && i == bp) baud_div_bi = 16'($urandom_range(0, 7));
      rx_i = (i == spike_off) ? 1'b0 : line_bit(b, stop, i / bp);
      @(posedge clk_i); #1;
    end
  endtask

  task automatic check_frame(input string tag, input logic exp_done, input logic [7:0] exp_byte,
                             input logic exp_err, input int exp_at, input logic [7:0] exp_dout);
    chk({tag, "_done_count"}, 32'(done_q.size()), 32'(exp_done));
    chk({tag, "_err_count"}, 32'(err_q.size()), 32'(exp_err));
    if (exp_done && done_q.size() == 1) begin
      chk({tag, "_done_data"}, 32'(done_q[0].data), 32'(exp_byte));
      chk({tag, "_done_cycle"}, 32'(done_q[0].at), 32'(exp_at));
    end
    if (exp_err && err_q.size() == 1) chk({tag, "_err_cycle"}, 32'(err_q[0]), 32'(exp_at));
    chk({tag, "_dout_hold"}, 32'(rx_dout_bo), 32'(exp_dout));
    chk({tag, "_busy_idle"}, 32'(busy_o), 32'd0);
    done_q.delete();
    err_q.delete();
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         d;
    logic       exp_done;
    logic       exp_err;
    logic [7:0] exp_dout;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[$];
    int         c, c2;
    logic [7:0] model_dout;
    logic [7:0] rb;
    logic       rstop;
    int         rd, rspike;

    rx_i        = 1'b1;
    baud_div_bi = '0;
    reset_n_i   = 1'b0;
    repeat (3) begin @(posedge clk_i); #1; end
    chk("reset_done", 32'(rx_done_tick_o), 32'd0);
    chk("reset_err", 32'(frame_err_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_dout", 32'(rx_dout_bo), 32'h00);
    reset_n_i = 1'b1;
    idle(5);

    // data, stop, clocks per tick, exp done, exp err, exp dout afterwards
    tbl.push_back('{8'hA5, 1'b1, 1, 1'b1, 1'b0, 8'hA5});
    tbl.push_back('{8'h00, 1'b1, 2, 1'b1, 1'b0, 8'h00});
    tbl.push_back('{8'hFF, 1'b1, 3, 1'b1, 1'b0, 8'hFF});
    tbl.push_back('{8'h3C, 1'b0, 1, 1'b0, 1'b1, 8'hFF});
    tbl.push_back('{8'h55, 1'b1, 1, 1'b1, 1'b0, 8'h55});
    tbl.push_back('{8'h81, 1'b1, 4, 1'b1, 1'b0, 8'h81});
    tbl.push_back('{8'h7E, 1'b0, 2, 1'b0, 1'b1, 8'h81});

    for (int unsigned k = 0; k < tbl.size(); k++) begin
      drive_frame(tbl[k].data, tbl[k].stop, tbl[k].d, -1, -1, 1'b0, c);
      if (!tbl[k].stop) begin
        hold_low(40);
        chk($sformatf("vec%0d_break_busy", k), 32'(busy_o), 32'd1);
      end
      idle(8);
      check_frame($sformatf("vec%0d", k), tbl[k].exp_done, tbl[k].data, tbl[k].exp_err,
                  exp_decision(c, tbl[k].d), tbl[k].exp_dout);
    end

    // False start: 5-clock low glitch
    baud_div_bi = '0;
    hold_low(5);
    chk("glitch_busy_start", 32'(busy_o), 32'd1);
    idle(40);
    check_frame("glitch", 1'b0, 8'h00, 1'b0, 0, 8'h81);

    // Back-to-back frames, no gap
    drive_frame(SYNC_BYTE, 1'b1, 4, -1, -1, 1'b0, c);
    drive_frame(ESCAPE_BYTE, 1'b1, 4, -1, -1, 1'b0, c2);
    idle(8);
    chk("b2b_done_count", 32'(done_q.size()), 32'd2);
    if (done_q.size() == 2) begin
      chk("b2b_first_data", 32'(done_q[0].data), 32'(SYNC_BYTE));
      chk("b2b_first_cycle", 32'(done_q[0].at), 32'(exp_decision(c, 4)));
      chk("b2b_second_data", 32'(done_q[1].data), 32'(ESCAPE_BYTE));
      chk("b2b_second_cycle", 32'(done_q[1].at), 32'(exp_decision(c2, 4)));
    end
    chk("b2b_err_count", 32'(err_q.size()), 32'd0);
    done_q.delete();
    err_q.delete();

    // Single-clock low spike landing on the middle sample of data bit 2
    drive_frame(8'hFF, 1'b1, 1, 3 * OVERSAMPLE + 9, -1, 1'b0, c);
    idle(8);
    check_frame("spike", 1'b1, 8'hFF, 1'b0, exp_decision(c, 1), 8'hFF);

    // Reset during data bit 4, then a clean frame
    drive_frame(8'hC3, 1'b1, 2, 5 * OVERSAMPLE * 2 + 8, 1'b0 ? 0 : 5 * OVERSAMPLE * 2 + 8, 1'b0, c);
    idle(10);
    check_frame("rst_abort", 1'b0, 8'h00, 1'b0, 0, 8'h00);
    drive_frame(8'h81, 1'b1, 1, -1, -1, 1'b0, c);
    idle(8);
    check_frame("after_rst", 1'b1, 8'h81, 1'b0, exp_decision(c, 1), 8'h81);
    model_dout = 8'h81;

    // Randomized frames: random byte, divider, stop validity, spike, divider scramble
    for (int n = 0; n < 40; n++) begin
      rb     = 8'($urandom);
      rd     = int'($urandom_range(1, 4));
      rstop  = ($urandom_range(0, 4) != 0);
      rspike = ($urandom_range(0, 1) == 1) ? int'($urandom_range(OVERSAMPLE * rd, 9 * OVERSAMPLE * rd - 1)) : -1;
      drive_frame(rb, rstop, rd, rspike, -1, 1'($urandom_range(0, 1)), c);
      if (!rstop) hold_low(int'($urandom_range(0, 30)));
      idle(8 + int'($urandom_range(0, 20)));
      if (rstop) model_dout = rb;
      check_frame($sformatf("rand%0d", n), rstop, rb, !rstop, exp_decision(c, rd), model_dout);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
